voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 81 ++++++++
 tb/tb_voice_mixer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed voice accumulator with latched mask/gain, headroom shift and saturation
module voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W = 8,
  parameter int HEADROOM = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_req,
  input  logic [NUM_VOICES-1:0] voice_active,
  input  logic [GAIN_W-1:0] gain,
  input  logic [SAMPLE_W-1:0] voice_in,
  input  logic clr_overrun,
  output logic [$clog2(NUM_VOICES)-1:0] voice_sel,
  output logic [SAMPLE_W-1:0] out,
  output logic out_valid,
  output logic clip,
  output logic busy,
  output logic overrun
);
  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int AW = SAMPLE_W + SEL_W;
  localparam int PW = AW + GAIN_W + 1;
  localparam int SH = GAIN_W - 1 + HEADROOM;
  localparam logic signed [PW-1:0] MAXV = {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] cnt;
  logic [NUM_VOICES-1:0] mask_q;
  logic [GAIN_W-1:0] gain_q;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod, shifted;
  logic sat_hi, sat_lo, accept, last;
  logic [SAMPLE_W-1:0] sat_val;
  always_comb begin
    accept = state == IDLE && sample_req;
    last = cnt == SEL_W'(NUM_VOICES - 1);
    state_nx = accept ? ACCUM :
               (state == ACCUM && last) ? SCALE :
               state == SCALE ? OUT :
               state == OUT ? IDLE : state;
    voice_sel = state == ACCUM ? cnt : '0;
    busy = state != IDLE;
    out_valid = state == OUT;
    // gain is unsigned, so a zero MSB keeps the signed product correct
    prod = PW'(acc) * PW'($signed({1'b0, gain_q}));
    shifted = prod >>> SH;
    sat_hi = shifted > MAXV;
    sat_lo = shifted < MINV;
    sat_val = sat_hi ? MAXV[SAMPLE_W-1:0] : sat_lo ? MINV[SAMPLE_W-1:0] : shifted[SAMPLE_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mask_q <= '0;
      gain_q <= '0;
      out <= '0;
      clip <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == ACCUM ? cnt + 1'b1 : '0;
      if (accept) begin
        mask_q <= voice_active;
        gain_q <= gain;
        acc <= '0;
      end else if (state == ACCUM && mask_q[cnt]) begin
        acc <= acc + AW'($signed(voice_in));
      end
      if (state == SCALE) begin
        out <= sat_val;
        clip <= sat_hi | sat_lo;
      end
      overrun <= (sample_req && state != IDLE) | (overrun & ~clr_overrun);
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized scoreboard bench for voice_mixer against an arithmetic reference model
module tb_voice_mixer;
  localparam int N = 8;
  localparam int SW = 16;
  localparam int GW = 8;
  logic clk = 0, rst = 1, sample_req = 0, clr_overrun = 0;
  logic [N-1:0] voice_active = '0;
  logic [GW-1:0] gain = '0;
  logic [SW-1:0] voice_in;
  logic [2:0] voice_sel;
  logic [SW-1:0] out;
  logic out_valid, clip, busy, overrun;
  logic [SW-1:0] voices [N];
  int cyc = 0, compared = 0, mismatched = 0;
  typedef struct {logic [SW-1:0] o; logic c; int t;} exp_t;
  exp_t q[$];

  voice_mixer dut (
    .clk(clk), .rst(rst), .sample_req(sample_req), .voice_active(voice_active),
    .gain(gain), .voice_in(voice_in), .clr_overrun(clr_overrun), .voice_sel(voice_sel),
    .out(out), .out_valid(out_valid), .clip(clip), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign voice_in = voices[voice_sel];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mixed value = floor(sum(active voices) * gain / 2^10), clamped to 16-bit signed
  function automatic exp_t model(input logic [N-1:0] m, input logic [GW-1:0] g);
    longint s;
    exp_t e;
    s = 0;
    for (int i = 0; i < N; i++) if (m[i]) s += longint'($signed(voices[i]));
    s = (s * longint'(g)) >>> 10;
    e.c = (s > 32767) || (s < -32768);
    e.o = s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : s[15:0];
    e.t = 0;
    return e;
  endfunction

  task automatic issue(input logic [N-1:0] m, input logic [GW-1:0] g);
    exp_t e;
    voice_active = m;
    gain = g;
    sample_req = 1;
    e = model(m, g);
    e.t = cyc + 10;
    q.push_back(e);
    @(negedge clk);
    sample_req = 0;
    voice_active = N'($urandom);
    gain = GW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic set_all(input logic [SW-1:0] v);
    for (int i = 0; i < N; i++) voices[i] = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) check("unexpected_valid_queue_depth", q.size(), 1);
      else begin
        e = q.pop_front();
        check("out", out, e.o);
        check("clip", clip, e.c);
        check("latency_cycle", cyc, e.t);
      end
    end
  end

  initial begin
    int v;
    set_all('0);
    repeat (2) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_voice_sel", voice_sel, 0);
    rst = 0;
    v = 0;
    repeat (20) begin
      @(negedge clk);
      v += int'(out_valid);
    end
    check("idle_valid_count", v, 0);

    set_all(16'h1000);
    issue(8'hff, 8'h80);
    for (int k = 0; k < N; k++) begin
      check("accum_voice_sel", voice_sel, k);
      check("accum_busy", busy, 1);
      @(negedge clk);
    end
    check("scale_voice_sel", voice_sel, 0);
    drain();

    set_all(16'h7fff);
    voices[3] = -16'sd8000;
    issue(8'h08, 8'h80);
    drain();
    set_all(16'h7fff);
    issue(8'hff, 8'hff);
    drain();
    set_all(16'h8000);
    issue(8'hff, 8'hff);
    drain();

    for (int i = 0; i < N; i++) voices[i] = SW'($urandom);
    issue(8'hff, 8'h80);
    repeat (2) @(negedge clk);
    voice_active = '0;
    @(negedge clk);
    sample_req = 1;
    @(negedge clk);
    sample_req = 0;
    check("overrun_set", overrun, 1);
    drain();
    check("overrun_sticky", overrun, 1);
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;
    check("overrun_cleared", overrun, 0);

    issue(8'h5a, 8'h40);
    sample_req = 1;
    clr_overrun = 1;
    @(negedge clk);
    sample_req = 0;
    clr_overrun = 0;
    check("overrun_set_beats_clr", overrun, 1);
    drain();
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;

    issue(8'hc3, 8'h90);
    repeat (9) @(negedge clk);
    check("out_cycle_valid", out_valid, 1);
    sample_req = 1;
    @(negedge clk);
    sample_req = 0;
    check("req_in_out_overrun", overrun, 1);
    check("idle_after_out_busy", busy, 0);
    issue(8'h3c, 8'h70);
    drain();
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;

    set_all(16'h1000);
    issue(8'hff, 8'h80);
    drain();
    issue(8'hff, 8'hff);
    repeat (4) @(negedge clk);
    rst = 1;
    void'(q.pop_back());
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_out", out, 0);
    check("abort_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    sample_req = 1;
    rst = 1;
    @(negedge clk);
    sample_req = 0;
    rst = 0;
    check("rst_beats_req_busy", busy, 0);
    issue(8'hf0, 8'h80);
    drain();

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        voices[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000) : SW'($urandom);
      issue(N'($urandom), GW'($urandom));
      drain();
    end

    check("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
